rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port between N_REQ writeback requesters: ALU (0), LOAD (1) and CSR (2) by default.
- Round-robin arbitration with a valid/ready handshake per requester.
- Optional multi-beat lock so one requester can hold the port for several consecutive writes.
- Registered write-port outputs; all state is held in register instances.

---
 rtl/rf_arb_pkg.sv | 8 +
 rtl/rf_wport_arbiter_reg.sv | 15 +
 rtl/rf_wport_arbiter_rr_pick.sv | 24 ++
 rtl/rf_wport_arbiter.sv | 84 ++++++++
 tb/tb_rf_wport_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types, constants and helpers for the register-file write-port arbiter
package rf_arb_pkg;
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_e;
  localparam int STAT_W = 16;
  function automatic int rr_idx_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_wport_arbiter_reg.sv
// rf_reg: enabled register with synchronous active-high clear, used for every flop in the arbiter
module rf_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk) begin
    if (rst) o_q <= '0;
    else if (i_en) o_q <= i_d;
  end
endmodule

// File: rtl/rf_wport_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; first valid bit at or above i_start, wrapping
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // scan from the far end so the candidate closest to i_start is written last and wins
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_start) + k) % N]) begin
        o_idx = IW'((int'(i_start) + k) % N);
        o_any = 1'b1;
      end
    end
  end
  assign o_grant = o_any ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: round-robin share of the register-file write port with multi-beat lock.
// Define RF_ARB_STATS_EN to build the per-requester saturating starvation counters.
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      stall,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [WIDTH-1:0]          rf_wdata,
  output logic                      locked,
  output logic [N_REQ*STAT_W-1:0]   stall_cnt
);
  localparam int IW = rr_idx_w(N_REQ);
  logic              r_state;
  logic [IW-1:0]     r_rr, r_owner, w_idx, w_pick_idx, w_rr_nxt;
  logic [N_REQ-1:0]  w_pick_grant;
  logic              w_pick_any, w_in_lock, w_acc, w_lock, w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  arb_state_e        w_state_nxt;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_valid(req_valid),
    .i_start(r_rr),
    .o_grant(w_pick_grant),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );
  assign w_in_lock = arb_state_e'(r_state) == LOCKED;
  always_comb begin
    req_ready = '0;
    w_idx = w_in_lock ? r_owner : w_pick_idx;
    if (!stall)
      req_ready = w_in_lock ? (req_valid[r_owner] ? (N_REQ'(1) << r_owner) : '0) : w_pick_grant;
  end
  assign w_acc       = |req_ready;
  assign w_lock      = req_lock[w_idx];
  assign w_addr      = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_data      = req_data[w_idx*WIDTH +: WIDTH];
  assign w_wr        = w_acc & |w_addr;
  assign w_state_nxt = w_lock ? LOCKED : ARB;
  assign w_rr_nxt    = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  rf_reg #(.W(1)) u_state (
    .clk, .rst, .i_en(w_acc), .i_d(w_state_nxt), .o_q(r_state)
  );
  rf_reg #(.W(IW)) u_rr (
    .clk, .rst, .i_en(w_acc & ~w_in_lock & w_pick_any), .i_d(w_rr_nxt), .o_q(r_rr)
  );
  rf_reg #(.W(IW)) u_owner (
    .clk, .rst, .i_en(w_acc & ~w_in_lock & w_lock), .i_d(w_idx), .o_q(r_owner)
  );
  rf_reg #(.W(1)) u_we (
    .clk, .rst, .i_en(1'b1), .i_d(w_wr), .o_q(rf_we)
  );
  // address and data only move on a real write so they hold across idle and x0 beats
  rf_reg #(.W(ADDR_W)) u_waddr (
    .clk, .rst, .i_en(w_wr), .i_d(w_addr), .o_q(rf_waddr)
  );
  rf_reg #(.W(WIDTH)) u_wdata (
    .clk, .rst, .i_en(w_wr), .i_d(w_data), .o_q(rf_wdata)
  );
  assign locked = w_in_lock;
`ifdef RF_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    logic [STAT_W-1:0] r_cnt;
    rf_reg #(.W(STAT_W)) u_cnt (
      .clk, .rst, .i_en(req_valid[g] & ~req_ready[g] & ~&r_cnt), .i_d(r_cnt + 1'b1), .o_q(r_cnt)
    );
    assign stall_cnt[g*STAT_W +: STAT_W] = r_cnt;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: vector table, corner sequences and randomized traffic against a behavioural model
module tb_rf_wport_arbiter;
  logic        clk = 1'b0;
  logic        rst, stall, rf_we, locked;
  logic [2:0]  req_valid, req_lock, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [47:0] stall_cnt;
  int checks = 0, errors = 0;
  bit          m_locked, m_we;
  int          m_rr, m_owner;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt[3];

  typedef struct {
    logic [2:0]  v, l;
    logic [14:0] a;
    logic [95:0] d;
    logic        s;
    logic [2:0]  er;
    logic        ewe;
    logic [4:0]  ea;
    logic        el;
  } vec_t;
  vec_t tbl[15];

  localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] A0   = {5'd3, 5'd2, 5'd0};
  localparam logic [14:0] A5   = {5'd3, 5'd2, 5'd5};
  localparam logic [95:0] D    = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
  localparam logic [95:0] DX   = {32'hCCCC0003, 32'hBBBB0002, 32'h0000DEAD};

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .locked(locked),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] m_cnt_packed();
    return {16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, "_we"}, 64'(rf_we), 64'(m_we));
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(m_waddr));
    chk({tag, "_wdata"}, 64'(rf_wdata), 64'(m_wdata));
    chk({tag, "_locked"}, 64'(locked), 64'(m_locked));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_cnt_packed()));
  endtask

  task automatic do_reset(input logic [2:0] v);
    rst = 1'b1; req_valid = v; req_lock = v; req_addr = A123; req_data = D; stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_locked = 0; m_we = 0; m_rr = 0; m_owner = 0; m_waddr = '0; m_wdata = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
  endtask

  // one cycle: drive, check the combinational grant, advance the model, check registered outputs
  task automatic apply(input logic [2:0] v, input logic [2:0] l, input logic [14:0] a,
                       input logic [95:0] d, input logic s, output logic [2:0] got);
    int win;
    logic [4:0] wa;
    req_valid = v; req_lock = l; req_addr = a; req_data = d; stall = s;
    #2;
    win = -1;
    if (!s) begin
      if (m_locked) begin
        if (v[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < 3; k++)
          if (win < 0 && v[(m_rr + k) % 3]) win = (m_rr + k) % 3;
      end
    end
    got = req_ready;
    chk("ready", 64'(req_ready), win < 0 ? 64'd0 : (64'd1 << win));
`ifdef RF_ARB_STATS_EN
    for (int i = 0; i < 3; i++)
      if (v[i] && win != i && m_cnt[i] < 65535) m_cnt[i]++;
`endif
    m_we = 0;
    if (win >= 0) begin
      wa = a[win*5 +: 5];
      if (wa != 0) begin
        m_we = 1; m_waddr = wa; m_wdata = d[win*32 +: 32];
      end
      if (!m_locked) begin
        m_rr = (win + 1) % 3;
        if (l[win]) begin
          m_locked = 1; m_owner = win;
        end
      end else if (!l[win]) m_locked = 0;
    end
    @(posedge clk); #1;
    chk_outputs("cyc");
  endtask

  initial begin
    logic [2:0] got;
    tbl[0]  = '{3'b111, 3'b000, A123, D,  1'b0, 3'b001, 1'b1, 5'd1, 1'b0};
    tbl[1]  = '{3'b111, 3'b000, A123, D,  1'b0, 3'b010, 1'b1, 5'd2, 1'b0};
    tbl[2]  = '{3'b111, 3'b000, A123, D,  1'b0, 3'b100, 1'b1, 5'd3, 1'b0};
    tbl[3]  = '{3'b010, 3'b000, A123, D,  1'b0, 3'b010, 1'b1, 5'd2, 1'b0};
    tbl[4]  = '{3'b101, 3'b000, A123, D,  1'b0, 3'b100, 1'b1, 5'd3, 1'b0};
    tbl[5]  = '{3'b101, 3'b000, A123, D,  1'b0, 3'b001, 1'b1, 5'd1, 1'b0};
    tbl[6]  = '{3'b111, 3'b010, A123, D,  1'b0, 3'b010, 1'b1, 5'd2, 1'b1};
    tbl[7]  = '{3'b111, 3'b010, A123, D,  1'b0, 3'b010, 1'b1, 5'd2, 1'b1};
    tbl[8]  = '{3'b111, 3'b000, A123, D,  1'b0, 3'b010, 1'b1, 5'd2, 1'b0};
    tbl[9]  = '{3'b111, 3'b000, A123, D,  1'b0, 3'b100, 1'b1, 5'd3, 1'b0};
    tbl[10] = '{3'b001, 3'b000, A0,   DX, 1'b0, 3'b001, 1'b0, 5'd3, 1'b0};
    tbl[11] = '{3'b001, 3'b000, A5,   D,  1'b0, 3'b001, 1'b1, 5'd5, 1'b0};
    tbl[12] = '{3'b100, 3'b100, A123, D,  1'b0, 3'b100, 1'b1, 5'd3, 1'b1};
    tbl[13] = '{3'b011, 3'b000, A123, D,  1'b0, 3'b000, 1'b0, 5'd3, 1'b1};
    tbl[14] = '{3'b111, 3'b000, A123, D,  1'b0, 3'b100, 1'b1, 5'd3, 1'b0};
    do_reset(3'b000);
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].d, tbl[i].s, got);
      chk($sformatf("tbl%0d_ready", i), 64'(got), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_we", i), 64'(rf_we), 64'(tbl[i].ewe));
      chk($sformatf("tbl%0d_waddr", i), 64'(rf_waddr), 64'(tbl[i].ea));
      chk($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].el));
    end
    // stall freezes grants while requester 2 waits
    do_reset(3'b000);
    for (int i = 0; i < 4; i++) begin
      apply(3'b100, 3'b000, A123, D, 1'b1, got);
      chk("stall_ready", 64'(got), 64'd0);
      chk("stall_we", 64'(rf_we), 64'd0);
    end
`ifdef RF_ARB_STATS_EN
    chk("stall_cnt2", 64'(stall_cnt[47:32]), 64'd4);
`else
    chk("stall_cnt2", 64'(stall_cnt[47:32]), 64'd0);
`endif
    apply(3'b100, 3'b000, A123, D, 1'b0, got);
    chk("unstall_ready", 64'(got), 64'b100);
    chk("unstall_waddr", 64'(rf_waddr), 64'd3);
    // reset in the middle of a lock held by requester 1
    do_reset(3'b000);
    apply(3'b010, 3'b010, A123, D, 1'b0, got);
    apply(3'b111, 3'b111, A123, D, 1'b0, got);
    chk("lock_hold_ready", 64'(got), 64'b010);
    chk("lock_hold_locked", 64'(locked), 64'd1);
    do_reset(3'b111);
    apply(3'b111, 3'b000, A123, D, 1'b0, got);
    chk("post_rst_ready", 64'(got), 64'b001);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset(3'($urandom));
      apply(3'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            ($urandom_range(0, 5) == 0) ? 15'($urandom & 32'h7BDE) : 15'($urandom),
            {$urandom, $urandom, $urandom}, $urandom_range(0, 7) == 0, got);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
